irq_pending_ctrl: RTL and testbench
===================================

// Module: irq_pending_ctrl
// PURPOSE
//  Upstream capture/arbitration stage for the 8:3 priority encoder path. Detects
//  rising edges on 8 request lines, holds them as sticky pending bits, applies a
//  mask, and presents the highest-priority unmasked pending index with a
//  valid/ack handshake. Bit 7 is highest priority, bit 0 lowest, matching the encoder.
// PARAMETERS
//  N      8  number of request lines (fixed at 8 for this revision)
//  IDX_W  3  index width, clog2(N)
// PORTS
//  clk        in   1      system clock, all logic on rising edge
//  rst        in   1      synchronous, active-high reset
//  req_in     in   N      request lines (level); a 0->1 transition raises a request
//  mask       in   N      1 = line enabled for presentation; 0 = held pending, not presented
//  irq_ack    in   1      consumer accepts the presented index (valid only while irq_valid=1)
//  irq_valid  out  1      irq_id holds a serviceable request
//  irq_id     out  IDX_W  index of presented request
//  pending    out  N      sticky pending register (raw, unmasked)
// BEHAVIOUR
//  Reset (rst=1 at clk edge): pending=0, irq_valid=0, irq_id=0, state=IDLE,
//   req_prev=all-ones (a line already high at reset release is NOT captured).
//  Edge detect: rise = req_in & ~req_prev; req_prev <= req_in every cycle.
//  Pending: pending <= (pending & ~clr) | rise; clr = onehot(irq_id) when
//   irq_valid & irq_ack, else 0. Set wins over clear on the same bit same cycle.
//  Eligible set: elig = pending & mask. Winner = highest set index of elig.
//  FSM, 2 states (all outputs registered):
//   IDLE:    if elig!=0 -> irq_id<=winner, irq_valid<=1, go PRESENT.
//   PRESENT: irq_id/irq_valid stable until acked. On irq_ack: clear pending[irq_id],
//            irq_valid<=0, go IDLE. Back-to-back requests thus have >=1 idle cycle.
//  No preemption: higher-priority arrival or mask change during PRESENT does not
//   alter irq_id; it is evaluated on return to IDLE.
//  Masking a bit mid-PRESENT: presented id still completes normally on ack.
//  irq_ack while irq_valid=0: ignored, no state change.
//  Latency: req_in rise sampled at edge k -> pending bit set after edge k ->
//   irq_valid=1 after edge k+1 (if IDLE and bit is winner).
//  Repeated rises on a line already pending: merged (no counting).
//  rst asserted mid-PRESENT: aborts presentation, all pending requests dropped.
// TESTING
//  1. Reset, req_in=0 -> rise on bit 2 -> pending=0x04 after 1 clk, irq_valid=1,
//     irq_id=2 after 2 clks; ack -> pending=0x00, irq_valid=0 next clk.
//  2. Rise on bits 1,5,7 same cycle -> ids presented 7,5,1 in order with ack each
//     time; one irq_valid=0 cycle between presentations.
//  3. mask=0x7F, rise on bits 7,3 -> id 3 presented; pending stays 0x80 after ack;
//     set mask=0xFF -> id 7 presented.
//  4. While presenting id 2, rise on bit 6 -> irq_id stays 2 until ack, then 6.
//  5. During PRESENT id 4, ack coincides with new rise on bit 4 -> pending[4]
//     remains 1 and id 4 presented again.
//  6. req_in=0xFF held through reset release -> pending stays 0; rst mid-PRESENT
//     -> irq_valid=0, pending=0 next clk; ack with irq_valid=0 has no effect.

Source files
------------

// File: rtl/irq_pending_ctrl_if.sv
// ----------------------------------------------------------------------------
// irq_pending_ctrl_if
//   Bundles the request, mask and presentation handshake of the interrupt
//   pending controller. The controller side uses the slave modport. The side
//   that raises requests and consumes presented indices uses the master modport.
//
//   req_in    : request lines (level); a 0->1 transition raises a request
//   mask      : 1 = line may be presented, 0 = held pending only
//   irq_ack   : consumer accepts the presented index
//   irq_valid : irq_id holds a serviceable request
//   irq_id    : index of the presented request
//   pending   : raw sticky pending register (unmasked)
// ----------------------------------------------------------------------------
interface irq_pending_ctrl_if #(
   parameter int N     = 8,
   parameter int IDX_W = $clog2(N)
);
   logic [N-1:0]     req_in;
   logic [N-1:0]     mask;
   logic             irq_ack;
   logic             irq_valid;
   logic [IDX_W-1:0] irq_id;
   logic [N-1:0]     pending;

   // Requester / consumer side
   modport master (
      output req_in,
      output mask,
      output irq_ack,
      input  irq_valid,
      input  irq_id,
      input  pending
   );

   // Controller side
   modport slave (
      input  req_in,
      input  mask,
      input  irq_ack,
      output irq_valid,
      output irq_id,
      output pending
   );
endinterface : irq_pending_ctrl_if

// File: rtl/irq_pending_ctrl.sv
// ----------------------------------------------------------------------------
// irq_pending_ctrl
//   Capture and arbitration stage in front of the 8:3 priority encoder.
//   The block watches 8 request lines for rising edges and holds each edge as a
//   sticky pending bit. It applies a mask to the pending bits. It presents the
//   highest unmasked pending index (bit 7 first) on a valid/ack handshake.
//   Once an index is presented it does not change until the consumer sends an
//   ack. Higher-priority arrivals and mask changes take effect only after the
//   controller returns to IDLE.
//
// Ports
//   i_clk : system clock, rising edge
//   i_rst : synchronous, active-high reset
//   bus   : irq_pending_ctrl_if.slave, which carries req_in, mask, irq_ack,
//           irq_valid, irq_id and pending
// ----------------------------------------------------------------------------
module irq_pending_ctrl #(
   parameter int N     = 8,
   parameter int IDX_W = $clog2(N)
) (
   input  logic                i_clk,
   input  logic                i_rst,
   irq_pending_ctrl_if.slave   bus
);

   typedef enum logic {
      IDLE    = 1'b0,
      PRESENT = 1'b1
   } state_t;

   state_t           r_state;
   logic [N-1:0]     r_req_prev;
   logic [N-1:0]     r_pending;
   logic             r_irq_valid;
   logic [IDX_W-1:0] r_irq_id;

   logic [N-1:0]     w_rise;
   logic [N-1:0]     w_clr;
   logic [N-1:0]     w_elig;
   logic [IDX_W-1:0] w_winner;

   // -------------------------------------------------------------------------
   // Edge detect, clear vector and eligible set
   // -------------------------------------------------------------------------
   assign w_rise = bus.req_in & ~r_req_prev;
   assign w_elig = r_pending & bus.mask;

   // A clear happens only on a real handshake. An ack while nothing is
   // presented does nothing.
   always_comb begin
      // NOTE: every signal that always_comb writes gets a default first, so no path can leave it unassigned and infer a latch.
      w_clr = '0;
      if (r_irq_valid && bus.irq_ack) begin
         w_clr[r_irq_id] = 1'b1;
      end
   end

   // Highest set index wins. The loop scans upward, so the last hit has the
   // highest priority.
   always_comb begin
      w_winner = '0;
      for (int i = 0; i < N; i++) begin
         if (w_elig[i]) begin
            w_winner = IDX_W'(i);
         end
      end
   end

   // -------------------------------------------------------------------------
   // State, pending register and registered outputs
   // -------------------------------------------------------------------------
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state     <= IDLE;
         r_pending   <= '0;
         r_irq_valid <= 1'b0;
         r_irq_id    <= '0;
         // req_prev resets to all-ones so that a line already high when reset
         // is released does not register as a fresh rise.
         r_req_prev  <= '1;
      end else begin
         // NOTE: sequential state uses non-blocking assignments, so every register samples pre-edge values and the block order does not matter.
         r_req_prev <= bus.req_in;
         // The rise term is ORed in after the clear, so a new edge on the bit
         // being acknowledged keeps that bit pending.
         r_pending  <= (r_pending & ~w_clr) | w_rise;

         unique case (r_state)
            IDLE: begin
               if (w_elig != '0) begin
                  r_irq_id    <= w_winner;
                  r_irq_valid <= 1'b1;
                  r_state     <= PRESENT;
               end
            end
            PRESENT: begin
               // irq_id is frozen here. Arbitration happens again only after
               // the controller returns to IDLE, which forces one idle cycle
               // between presentations.
               if (bus.irq_ack) begin
                  r_irq_valid <= 1'b0;
                  r_state     <= IDLE;
               end
            end
            default: begin
               r_state     <= IDLE;
               r_irq_valid <= 1'b0;
            end
         endcase
      end
   end

   assign bus.irq_valid = r_irq_valid;
   assign bus.irq_id    = r_irq_id;
   assign bus.pending   = r_pending;

endmodule : irq_pending_ctrl

// File: tb/tb_irq_pending_ctrl.sv
// ----------------------------------------------------------------------------
// tb_irq_pending_ctrl
//   Directed bench for irq_pending_ctrl. Inputs change 1 ns after a rising
//   edge. Outputs are sampled 1 ns after the next rising edge. Each expected
//   value below was worked out by hand from the block's behaviour.
// ----------------------------------------------------------------------------
module tb_irq_pending_ctrl;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_fail;

   irq_pending_ctrl_if #(.N(8)) bus ();

   irq_pending_ctrl #(.N(8)) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one rising edge and settle just after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Compare valid, id and pending together.
   task automatic check_all(input string tag, input logic v, input logic [2:0] id,
                            input logic [7:0] pend);
      check({tag, ".valid"},   {7'd0, bus.irq_valid}, {7'd0, v});
      check({tag, ".id"},      {5'd0, bus.irq_id},    {5'd0, id});
      check({tag, ".pending"}, bus.pending,           pend);
   endtask

   task automatic check_vp(input string tag, input logic v, input logic [7:0] pend);
      check({tag, ".valid"},   {7'd0, bus.irq_valid}, {7'd0, v});
      check({tag, ".pending"}, bus.pending,           pend);
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      rst         = 1'b1;
      bus.req_in  = 8'h00;
      bus.mask    = 8'hFF;
      bus.irq_ack = 1'b0;
      tick();
      tick();
      check_all("reset", 1'b0, 3'd0, 8'h00);

      // ---- 1: single rise on bit 2, latency and ack --------------------------
      rst = 1'b0;
      tick();                                 // req_prev becomes 0
      bus.req_in = 8'h04;
      tick();
      check_vp("t1.after_rise", 1'b0, 8'h04);
      tick();
      check_all("t1.present", 1'b1, 3'd2, 8'h04);
      bus.irq_ack = 1'b1;
      tick();
      check_vp("t1.acked", 1'b0, 8'h00);
      bus.irq_ack = 1'b0;
      bus.req_in  = 8'h00;
      tick();
      check_vp("t1.idle", 1'b0, 8'h00);

      // ---- 2: bits 1,5,7 together, presented 7,5,1 with an idle gap ----------
      bus.req_in = 8'hA2;
      tick();
      check_vp("t2.captured", 1'b0, 8'hA2);
      bus.req_in = 8'h00;
      tick();
      check_all("t2.id7", 1'b1, 3'd7, 8'hA2);
      bus.irq_ack = 1'b1;
      tick();
      check_vp("t2.gap1", 1'b0, 8'h22);
      bus.irq_ack = 1'b0;
      tick();
      check_all("t2.id5", 1'b1, 3'd5, 8'h22);
      bus.irq_ack = 1'b1;
      tick();
      check_vp("t2.gap2", 1'b0, 8'h02);
      bus.irq_ack = 1'b0;
      tick();
      check_all("t2.id1", 1'b1, 3'd1, 8'h02);
      bus.irq_ack = 1'b1;
      tick();
      check_vp("t2.done", 1'b0, 8'h00);
      bus.irq_ack = 1'b0;

      // ---- 3: masked bit 7 stays pending until unmasked ----------------------
      bus.mask   = 8'h7F;
      bus.req_in = 8'h88;
      tick();
      check_vp("t3.captured", 1'b0, 8'h88);
      bus.req_in = 8'h00;
      tick();
      check_all("t3.id3", 1'b1, 3'd3, 8'h88);
      bus.irq_ack = 1'b1;
      tick();
      check_vp("t3.acked", 1'b0, 8'h80);
      bus.irq_ack = 1'b0;
      tick();
      check_vp("t3.masked_hold", 1'b0, 8'h80);
      bus.mask = 8'hFF;
      tick();
      check_all("t3.id7", 1'b1, 3'd7, 8'h80);
      bus.irq_ack = 1'b1;
      tick();
      check_vp("t3.done", 1'b0, 8'h00);
      bus.irq_ack = 1'b0;

      // ---- 4: no preemption by a higher-priority arrival ---------------------
      bus.req_in = 8'h04;
      tick();
      bus.req_in = 8'h00;
      tick();
      check_all("t4.id2", 1'b1, 3'd2, 8'h04);
      bus.req_in = 8'h40;
      tick();
      check_all("t4.hold_a", 1'b1, 3'd2, 8'h44);
      bus.req_in = 8'h00;
      tick();
      check_all("t4.hold_b", 1'b1, 3'd2, 8'h44);
      bus.irq_ack = 1'b1;
      tick();
      check_vp("t4.acked", 1'b0, 8'h40);
      bus.irq_ack = 1'b0;
      tick();
      check_all("t4.id6", 1'b1, 3'd6, 8'h40);
      bus.irq_ack = 1'b1;
      tick();
      check_vp("t4.done", 1'b0, 8'h00);
      bus.irq_ack = 1'b0;

      // ---- 5: ack coincides with a new rise on the same bit ------------------
      bus.req_in = 8'h10;
      tick();
      bus.req_in = 8'h00;
      tick();
      check_all("t5.id4", 1'b1, 3'd4, 8'h10);
      bus.req_in  = 8'h10;
      bus.irq_ack = 1'b1;
      tick();
      check_vp("t5.set_wins", 1'b0, 8'h10);
      bus.req_in  = 8'h00;
      bus.irq_ack = 1'b0;
      tick();
      check_all("t5.id4_again", 1'b1, 3'd4, 8'h10);
      bus.irq_ack = 1'b1;
      tick();
      check_vp("t5.done", 1'b0, 8'h00);
      bus.irq_ack = 1'b0;

      // ---- 6: lines high through reset, reset mid-PRESENT, stray ack ---------
      bus.req_in = 8'hFF;
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      tick();
      check_vp("t6.no_capture_a", 1'b0, 8'h00);
      tick();
      check_vp("t6.no_capture_b", 1'b0, 8'h00);
      bus.req_in = 8'h00;
      tick();
      bus.req_in = 8'h03;
      tick();
      bus.req_in = 8'h00;
      tick();
      check_all("t6.id1", 1'b1, 3'd1, 8'h03);
      rst = 1'b1;
      tick();
      check_all("t6.rst_abort", 1'b0, 3'd0, 8'h00);
      rst = 1'b0;
      tick();
      check_vp("t6.after_rst", 1'b0, 8'h00);
      bus.mask   = 8'h00;
      bus.req_in = 8'h08;
      tick();
      check_vp("t6.masked_pend", 1'b0, 8'h08);
      bus.req_in  = 8'h00;
      bus.irq_ack = 1'b1;
      tick();
      check_vp("t6.stray_ack", 1'b0, 8'h08);
      bus.irq_ack = 1'b0;
      bus.mask    = 8'hFF;
      tick();
      check_all("t6.id3", 1'b1, 3'd3, 8'h08);
      bus.irq_ack = 1'b1;
      tick();
      check_vp("t6.done", 1'b0, 8'h00);
      bus.irq_ack = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule : tb_irq_pending_ctrl
